// File: rtl/arith_seq_unit.sv
// ============================================================================
// Module   : arith_seq_unit
// Brief    : Registered multi-cycle signed add/sub/mul/div unit with
//            valid/ready request and result handshakes. Division is an
//            iterative restoring divider producing one quotient bit per cycle.
// Options  : ARITH_SEQ_DIVZ_FLAG_EN - adds the divz output flagging results
//            that came from a divide by zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             busy
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
  ,
  output logic             divz
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] r_q, r_d;

  // Divider state: partial remainder and divisor magnitude carry one extra
  // bit so that |MIN| is representable; the quotient register starts out
  // holding the dividend magnitude and shifts quotient bits in from the right.
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef ARITH_SEQ_DIVZ_FLAG_EN
  logic             divz_q, divz_d;
`endif

  logic             w_accept;
  logic             w_b_zero;
  logic [WIDTH:0]   w_a_ext, w_b_ext;
  logic [WIDTH:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic             w_neg;
  logic             w_unused;

  assign w_accept = in_valid && (state_q == S_IDLE);
  assign w_b_zero = (b == '0);

  // Magnitudes of the incoming operands, computed one bit wider than WIDTH.
  assign w_a_ext  = {a[WIDTH-1], a};
  assign w_b_ext  = {b[WIDTH-1], b};
  assign w_mag_a  = a[WIDTH-1] ? ((WIDTH+1)'(0) - w_a_ext) : w_a_ext;
  assign w_mag_b  = b[WIDTH-1] ? ((WIDTH+1)'(0) - w_b_ext) : w_b_ext;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits.
  assign w_trial  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign w_ge     = (w_trial >= dvs_q);
  assign w_neg    = a_q[WIDTH-1] ^ b_q[WIDTH-1];

  // The remainder top bit and the dividend magnitude top bit never feed the
  // quotient (remainder stays below the divisor, |a| fits in WIDTH bits).
  assign w_unused = rem_q[WIDTH] ^ w_mag_a[WIDTH];

  assign r        = r_q;
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
  assign divz     = divz_q;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = ((sel == 2'd3) && !w_b_zero) ? S_DIV : S_CALC;
        end
      end
      S_CALC: state_d = S_DONE;
      S_DIV: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: operand capture, single-cycle ops, divider steps.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sel_d  = sel_q;
    r_d    = r_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
    divz_d = divz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          a_d   = a;
          b_d   = b;
          sel_d = sel;
          rem_d = '0;
          quo_d = w_mag_a[WIDTH-1:0];
          dvs_d = w_mag_b;
          cnt_d = '0;
        end
      end
      S_CALC: begin
        case (sel_q)
          2'd0:    r_d = a_q + b_q;
          2'd1:    r_d = a_q - b_q;
          2'd2:    r_d = a_q * b_q;
          default: r_d = '1;  // only divide-by-zero reaches CALC with sel=3
        endcase
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
        divz_d = (sel_q == 2'd3);
`endif
      end
      S_DIV: begin
        rem_d = w_ge ? (w_trial - dvs_q) : w_trial;
        quo_d = {quo_q[WIDTH-2:0], w_ge};
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        // MIN / -1 yields magnitude 2^(WIDTH-1), which wraps back to MIN.
        r_d = w_neg ? ('0 - quo_q) : quo_q;
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
        divz_d = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= '0;
      r_q    <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
      divz_q <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sel_q  <= sel_d;
      r_q    <= r_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
      divz_q <= divz_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arith_seq_unit.sv
// ============================================================================
// Module   : tb_arith_seq_unit
// Brief    : Self-checking bench for arith_seq_unit (WIDTH=32): directed
//            cases, backpressure, mid-operation reset and a randomized
//            regression against a plain-arithmetic reference model.
//            Honours ARITH_SEQ_DIVZ_FLAG_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_seq_unit;

  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;
  localparam logic [31:0] MAX = 32'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  r;
  logic          busy;
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
  logic          divz;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  arith_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .busy      (busy)
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
    ,
    .divz      (divz)
`endif
  );

  // Reference result from plain 64-bit signed arithmetic.
  function automatic logic [31:0] ref_r(input logic [31:0] ta, input logic [31:0] tb_v,
                                        input logic [1:0] ts);
    longint sa, sb, res;
    sa = $signed(ta);
    sb = $signed(tb_v);
    case (ts)
      2'd0:    res = sa + sb;
      2'd1:    res = sa - sb;
      2'd2:    res = sa * sb;
      default: res = (sb == 0) ? -1 : (sa / sb);
    endcase
    return res[31:0];
  endfunction

  // Cycles from accept edge to out_valid.
  function automatic int ref_lat(input logic [31:0] tb_v, input logic [1:0] ts);
    return (ts == 2'd3 && tb_v != 0) ? (W + 1) : 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return MIN;
      4:       return MAX;
      default: return $urandom;
    endcase
  endfunction

  // Present a request, wait for its accept, then count cycles to out_valid.
  // Called and returns at 1 time unit after a rising edge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [1:0] ts, output int lat);
    int guard;
    guard    = 0;
    a        = ta;
    b        = tb_v;
    sel      = ts;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    sel      = 2'($urandom);
    lat      = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Optionally stall the result for some cycles, then take it.
  task automatic retire(input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sel       = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, r} !== {1'b1, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset: in_ready=%0b out_valid=%0b busy=%0b r=%h, want 1 0 0 00000000",
               in_ready, out_valid, busy, r);
    else n_pass++;
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
    n_checks++;
    if (divz !== 1'b0) $display("FAIL reset_divz: got %0b want 0", divz);
    else n_pass++;
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub_mul();
    logic [31:0] va [4] = '{MAX, 32'd5, 32'h0001_0000, 32'hFFFF_FFFD};
    logic [31:0] vb [4] = '{32'd1, 32'd9, 32'h0001_0000, 32'd7};
    logic [1:0]  vs [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [31:0] ve [4] = '{MIN, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFEB};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vs[i], lat);
      n_checks++;
      if (r !== ve[i]) $display("FAIL arith_r[%0d]: got %h want %h", i, r, ve[i]);
      else n_pass++;
      n_checks++;
      if (lat !== 1) $display("FAIL arith_lat[%0d]: got %0d want 1", i, lat);
      else n_pass++;
      retire(0);
    end
  endtask

  task automatic test_div();
    logic [31:0] va [3] = '{32'hFFFF_FFF9, 32'd100, MIN};
    logic [31:0] vb [3] = '{32'd2, 32'hFFFF_FFF6, 32'hFFFF_FFFF};
    logic [31:0] ve [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFF6, MIN};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], 2'd3, lat);
      n_checks++;
      if (r !== ve[i]) $display("FAIL div_r[%0d]: got %h want %h", i, r, ve[i]);
      else n_pass++;
      n_checks++;
      if (lat !== W + 1) $display("FAIL div_lat[%0d]: got %0d want %0d", i, lat, W + 1);
      else n_pass++;
      retire(1);
    end
  endtask

  task automatic test_divzero();
    int lat;
    issue(32'd1234, 32'd0, 2'd3, lat);
    n_checks++;
    if ({r, 32'(lat)} !== {32'hFFFF_FFFF, 32'd1})
      $display("FAIL divzero: r=%h lat=%0d want ffffffff 1", r, lat);
    else n_pass++;
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
    n_checks++;
    if (divz !== 1'b1) $display("FAIL divz_set: got %0b want 1", divz);
    else n_pass++;
`endif
    retire(0);
    issue(32'd4, 32'd2, 2'd3, lat);
    n_checks++;
    if (r !== 32'd2) $display("FAIL div_after_divzero: got %h want 00000002", r);
    else n_pass++;
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
    n_checks++;
    if (divz !== 1'b0) $display("FAIL divz_clear: got %0b want 0", divz);
    else n_pass++;
`endif
    retire(0);
  endtask

  task automatic test_backpressure();
    int lat;
    issue(32'd3, 32'd4, 2'd0, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 5);
      a        = 32'd99;
      b        = 32'd1;
      sel      = 2'd0;
      n_checks++;
      if ({r, in_ready, out_valid} !== {32'd7, 1'b0, 1'b1})
        $display("FAIL backpressure[%0d]: r=%h in_ready=%0b out_valid=%0b want 00000007 0 1",
                 i, r, in_ready, out_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, out_valid} !== 2'b00)
      $display("FAIL bp_no_queue: busy=%0b out_valid=%0b want 0 0", busy, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    a        = 32'hFFFF_FF9C;
    b        = 32'd7;
    sel      = 2'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, r} !== {1'b1, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset_mid: in_ready=%0b out_valid=%0b busy=%0b r=%h want 1 0 0 00000000",
               in_ready, out_valid, busy, r);
    else n_pass++;
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL reset_mid_no_result: got %0d valid cycles want 0", seen);
    else n_pass++;
    issue(32'd9, 32'd3, 2'd3, lat);
    n_checks++;
    if ({r, 32'(lat)} !== {32'd3, 32'(W + 1)})
      $display("FAIL after_reset_div: r=%h lat=%0d want 00000003 %0d", r, lat, W + 1);
    else n_pass++;
    retire(0);
  endtask

  task automatic test_random();
    logic [31:0] ta, tb_v, exp_r;
    logic [1:0]  ts;
    int          lat, exp_lat;
    for (int n = 0; n < 1200; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      ta      = pick_operand();
      tb_v    = pick_operand();
      ts      = 2'($urandom_range(0, 3));
      exp_r   = ref_r(ta, tb_v, ts);
      exp_lat = ref_lat(tb_v, ts);
      issue(ta, tb_v, ts, lat);
      n_checks++;
      if ({r, 32'(lat)} !== {exp_r, 32'(exp_lat)}) begin
        $display("FAIL random[%0d] a=%h b=%h sel=%0d: r=%h lat=%0d want %h %0d",
                 n, ta, tb_v, ts, r, lat, exp_r, exp_lat);
        if (lat < 0) break;
      end else n_pass++;
`ifdef ARITH_SEQ_DIVZ_FLAG_EN
      n_checks++;
      if (divz !== (ts == 2'd3 && tb_v == 0))
        $display("FAIL random_divz[%0d]: got %0b want %0b", n, divz, (ts == 2'd3 && tb_v == 0));
      else n_pass++;
`endif
      retire($urandom_range(0, 3));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_sub_mul();
    test_div();
    test_divzero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
